commit_free_list: RTL and testbench

Retirement-side consumer of the reorder buffer's commit stream for one register class. It holds the committed architectural-to-physical map and a circular free list of physical tags. Each commit with a destination returns the superseded physical tag to the free list, and rename pops new tags from it. It sits between the ROB commit port and the rename stage, with one instance each for the D and S register files.

---
 rtl/commit_free_list_pkg.sv | 19 +
 rtl/commit_free_list_tag_queue.sv | 76 +++++++
 rtl/commit_free_list.sv | 62 ++++++
 tb/tb_commit_free_list.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_free_list_pkg.sv
// Shared register-class sizing and tag types for the commit-side free lists.
package commit_free_list_pkg;

    localparam int NUM_D_REG  = 8;
    localparam int NUM_S_REG  = 8;
    localparam int NUM_D_PHYS = 2 * NUM_D_REG;
    localparam int NUM_S_PHYS = 2 * NUM_S_REG;

    typedef logic [$clog2(NUM_D_PHYS)-1:0] d_phys_tag_t;
    typedef logic [$clog2(NUM_D_REG)-1:0]  d_arch_addr_t;
    typedef logic [$clog2(NUM_S_PHYS)-1:0] s_phys_tag_t;
    typedef logic [$clog2(NUM_S_REG)-1:0]  s_arch_addr_t;

    // Index width that stays legal when a structure has a single entry.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/commit_free_list_tag_queue.sv
// Circular tag buffer with push, pop, reset-to-full and head restore to the post-push tail.
module tag_queue
    import commit_free_list_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter int  TAG_W = 4,
    parameter int  BASE  = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop_req,
    input  logic             restore,
    output logic [TAG_W-1:0] head_tag,
    output logic             nonempty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = clog2_min1(DEPTH);

    logic [TAG_W-1:0] buffer [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] tail_next;
    logic             pop;

    // DEPTH need not be a power of two, so wrap by compare rather than truncation.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign nonempty  = (count != '0);
    assign head_tag  = buffer[head];
    assign pop       = pop_req & nonempty & ~restore;
    assign tail_next = push ? ptr_inc(tail) : tail;

    // NOTE: the tag storage is reset on purpose; every physical tag must start out free.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                buffer[j] <= TAG_W'(BASE + j);
            end
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(DEPTH);
        end else begin
            if (push) begin
                buffer[tail] <= push_tag;
            end
            tail <= tail_next;
            if (restore) begin
                head  <= tail_next;
                count <= CNT_W'(DEPTH);
            end else begin
                if (pop) begin
                    head <= ptr_inc(head);
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!n_rst)
        int'(count) <= DEPTH);
    a_no_push_full: assert property (@(posedge clk) disable iff (!n_rst)
        !(push && count == CNT_W'(DEPTH)));
    a_ptr_consistent: assert property (@(posedge clk) disable iff (!n_rst)
        int'(tail) == (int'(head) + int'(count)) % DEPTH);

endmodule

// File: rtl/commit_free_list.sv
// Committed arch-to-phys map plus the free list fed by superseded tags at retirement.
module commit_free_list
    import commit_free_list_pkg::*;
#(
    parameter int  ARCH_REGS = NUM_D_REG,
    parameter int  PHYS_REGS = 2 * NUM_D_REG,
    localparam int DEPTH     = PHYS_REGS - ARCH_REGS,
    localparam int TAG_W     = $clog2(PHYS_REGS),
    localparam int ARCH_W    = clog2_min1(ARCH_REGS),
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              alloc_req,
    output logic              alloc_valid,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              commit_valid,
    input  logic              commit_use,
    input  logic [ARCH_W-1:0] commit_arch,
    input  logic [TAG_W-1:0]  commit_phys,
    input  logic              flush,
    input  logic [ARCH_W-1:0] map_rd_addr,
    output logic [TAG_W-1:0]  map_rd_tag,
    output logic [CNT_W-1:0]  free_count
);

    logic [TAG_W-1:0] committed_map [ARCH_REGS];
    logic             push;
    logic [TAG_W-1:0] old_tag;

    assign push       = commit_valid & commit_use;
    assign old_tag    = committed_map[commit_arch];
    assign map_rd_tag = committed_map[map_rd_addr];

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                committed_map[i] <= TAG_W'(i);
            end
        end else if (push) begin
            committed_map[commit_arch] <= commit_phys;
        end
    end

    // Flush restores the head to the post-commit tail: committed state always has DEPTH free tags.
    tag_queue #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .BASE  (ARCH_REGS)
    ) u_tag_queue (
        .clk      (clk),
        .n_rst    (n_rst),
        .push     (push),
        .push_tag (old_tag),
        .pop_req  (alloc_req),
        .restore  (flush),
        .head_tag (alloc_tag),
        .nonempty (alloc_valid),
        .count    (free_count)
    );

endmodule

// File: tb/tb_commit_free_list.sv
// Bench for commit_free_list (ARCH_REGS=8, PHYS_REGS=16): vector table, corner sequences, random vs queue model.
module tb_commit_free_list;

    localparam int ARCH  = 8;
    localparam int PHYS  = 16;
    localparam int DEPTH = PHYS - ARCH;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       alloc_req;
    logic       alloc_valid;
    logic [3:0] alloc_tag;
    logic       commit_valid;
    logic       commit_use;
    logic [2:0] commit_arch;
    logic [3:0] commit_phys;
    logic       flush;
    logic [2:0] map_rd_addr;
    logic [3:0] map_rd_tag;
    logic [3:0] free_count;

    int n_checks = 0;
    int n_fail   = 0;

    commit_free_list #(.ARCH_REGS(ARCH), .PHYS_REGS(PHYS)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .alloc_req    (alloc_req),
        .alloc_valid  (alloc_valid),
        .alloc_tag    (alloc_tag),
        .commit_valid (commit_valid),
        .commit_use   (commit_use),
        .commit_arch  (commit_arch),
        .commit_phys  (commit_phys),
        .flush        (flush),
        .map_rd_addr  (map_rd_addr),
        .map_rd_tag   (map_rd_tag),
        .free_count   (free_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: free tags in pop order, log of every tag ever freed, committed map, tags in flight.
    int ref_map [ARCH];
    int free_q[$];
    int hist[$];
    int inflight[$];

    task automatic model_reset();
        free_q.delete();
        hist.delete();
        inflight.delete();
        for (int i = 0; i < ARCH; i++) ref_map[i] = i;
        for (int j = ARCH; j < PHYS; j++) begin
            free_q.push_back(j);
            hist.push_back(j);
        end
    endtask

    task automatic model_update();
        int t;
        if (!n_rst) begin
            model_reset();
        end else begin
            if (alloc_req && free_q.size() > 0 && !flush) begin
                t = free_q.pop_front();
                inflight.push_back(t);
            end
            if (commit_valid && commit_use) begin
                t = ref_map[commit_arch];
                free_q.push_back(t);
                hist.push_back(t);
                ref_map[commit_arch] = int'(commit_phys);
                for (int k = 0; k < inflight.size(); k++) begin
                    if (inflight[k] == int'(commit_phys)) begin
                        inflight.delete(k);
                        break;
                    end
                end
            end
            if (flush) begin
                // After a flush the free tags are the DEPTH most recently freed ones, oldest first.
                free_q.delete();
                for (int k = hist.size() - DEPTH; k < hist.size(); k++) free_q.push_back(hist[k]);
                inflight.delete();
            end
        end
    endtask

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic check_model();
        check("valid", int'(alloc_valid), (free_q.size() > 0) ? 1 : 0);
        check("count", int'(free_count), free_q.size());
        if (free_q.size() > 0) check("tag", int'(alloc_tag), free_q[0]);
        check("map", int'(map_rd_tag), ref_map[map_rd_addr]);
    endtask

    // Inputs are set while clk is low; outputs are checked there, then the edge is taken.
    task automatic tick();
        check_model();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive(input bit ar, input bit cv, input bit cu, input int ca, input int cp,
                         input bit fl);
        alloc_req    = ar;
        commit_valid = cv;
        commit_use   = cu;
        commit_arch  = 3'(ca);
        commit_phys  = 4'(cp);
        flush        = fl;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        n_rst = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic pop_n(input int n);
        repeat (n) begin
            drive(1, 0, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        bit ar; bit cv; bit cu; int ca; int cp; bit fl; int ma;
        bit ev; bit ct; int et; int ec; int em;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int exp_seq [4];
        n_rst = 1'b0;
        map_rd_addr = '0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        do_reset();

        // Pop all 8 reset tags, over-request once while empty with a commit, then drain the freed tag.
        for (int i = 0; i < 8; i++)
            vecs[i] = '{1, 0, 0, 0, 0, 0, i, 1, 1, 8 + i, 8 - i, i};
        vecs[8]  = '{1, 1, 1, 3, 8, 0, 3, 0, 0, 0, 0, 3};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 3, 1, 1, 3, 1, 8};
        vecs[10] = '{1, 1, 0, 5, 9, 0, 5, 1, 1, 3, 1, 5};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 5};

        for (int r = 0; r < 12; r++) begin
            drive(vecs[r].ar, vecs[r].cv, vecs[r].cu, vecs[r].ca, vecs[r].cp, vecs[r].fl);
            map_rd_addr = 3'(vecs[r].ma);
            #1;
            check($sformatf("vec%0d_valid", r), int'(alloc_valid), int'(vecs[r].ev));
            check($sformatf("vec%0d_count", r), int'(free_count), vecs[r].ec);
            if (vecs[r].ct) check($sformatf("vec%0d_tag", r), int'(alloc_tag), vecs[r].et);
            check($sformatf("vec%0d_map", r), int'(map_rd_tag), vecs[r].em);
            @(posedge clk);
            @(negedge clk);
        end

        // Same-cycle pop and commit at count 4: count holds, old tag 0 waits behind 13,14,15.
        do_reset();
        pop_n(4);
        check("s3_count_before", int'(free_count), 4);
        drive(1, 1, 1, 0, 8, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("s3_count_after", int'(free_count), 4);
        exp_seq = '{13, 14, 15, 0};
        for (int k = 0; k < 4; k++) begin
            check($sformatf("s3_pop%0d", k), int'(alloc_tag), exp_seq[k]);
            drive(1, 0, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        check("s3_empty", int'(alloc_valid), 0);

        // Pop 5, commit 2, flush: the head returns to the oldest freed tag.
        do_reset();
        pop_n(5);
        drive(0, 1, 1, 2, 8, 0);
        tick();
        drive(0, 1, 1, 6, 9, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("s4_count", int'(free_count), 8);
        check("s4_valid", int'(alloc_valid), 1);
        check("s4_first_tag", int'(alloc_tag), 10);
        pop_n(8);

        // Flush together with a commit: the commit lands and its old tag joins the list.
        do_reset();
        pop_n(2);
        drive(0, 1, 1, 1, 9, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        map_rd_addr = 3'd1;
        #1;
        check("s5_map1", int'(map_rd_tag), 9);
        check("s5_count", int'(free_count), 8);
        check("s5_tag", int'(alloc_tag), 9);
        pop_n(7);
        check("s5_old_tag_last", int'(alloc_tag), 1);

        // Reset in the middle of traffic, with active inputs during the reset edge.
        do_reset();
        pop_n(3);
        drive(0, 1, 1, 4, 8, 0);
        tick();
        n_rst = 1'b0;
        drive(1, 1, 1, 5, 9, 0);
        tick();
        n_rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        check("s6_count", int'(free_count), 8);
        check("s6_valid", int'(alloc_valid), 1);
        check("s6_tag", int'(alloc_tag), 8);
        for (int i = 0; i < ARCH; i++) begin
            map_rd_addr = 3'(i);
            #1;
            check($sformatf("s6_map%0d", i), int'(map_rd_tag), i);
        end

        // Random traffic; commits retire tags that are actually in flight.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bit ar, cv, cu, fl;
            int ca, cp;
            ar = 1'($urandom_range(0, 1));
            cv = 1'($urandom_range(0, 2) == 0);
            cu = 1'($urandom_range(0, 3) != 0);
            ca = int'($urandom_range(0, ARCH - 1));
            cp = int'($urandom_range(0, PHYS - 1));
            fl = 1'($urandom_range(0, 31) == 0);
            if (cv && cu) begin
                if (inflight.size() > 0) cp = inflight[0];
                else cv = 1'b0;
            end
            drive(ar, cv, cu, ca, cp, fl);
            map_rd_addr = 3'($urandom_range(0, ARCH - 1));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        check_model();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
